// File: rtl/dram_rr_arbiter.sv
// Round-robin sequencer that shares one single-port RAM among NCORES cores.
// Same-address reads are merged into one RAM access; ext_hold lends the RAM to another master.
module dram_rr_arbiter #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    input  logic                 ext_hold,
    input  logic [DW-1:0]        ram_q,
    output logic [NCORES-1:0]    ack,
    output logic [NCORES*DW-1:0] rdata,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_din,
    output logic                 ram_wren,
    output logic                 busy
);
    // state | meaning
    // IDLE  | sample requests; RAM address/data hold their last value
    // ISSUE | RAM address/data/wren presented for exactly one cycle
    // WAIT  | read latency down-count; ram_q captured at terminal count
    // DONE  | ack pulse to the grant mask; priority pointer advances

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     scan_idx;
    logic [NCORES-1:0] grant;
    logic [NCORES-1:0] win_mask;
    logic [CW-1:0]     cnt;
    logic              win_found;
    logic              win_we;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_wdata;
    logic              start;
    logic              cnt_tc;

    // First requester at or after ptr, wrapping modulo NCORES.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NCORES; i++) begin
            scan_idx = PW'((int'(ptr) + i) % NCORES);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (win_idx == PW'(k)) begin
                win_we    = we[k];
                win_addr  = addr[k*AW +: AW];
                win_wdata = wdata[k*DW +: DW];
            end
        end
    end

    // A read winner pulls in every other pending read of the same address.
    always_comb begin
        win_mask = '0;
        for (int k = 0; k < NCORES; k++) begin
            if (win_idx == PW'(k)) begin
                win_mask[k] = 1'b1;
            end else if (!win_we && req[k] && !we[k] && (addr[k*AW +: AW] == win_addr)) begin
                win_mask[k] = 1'b1;
            end
        end
    end

    assign start  = (state == IDLE) && win_found && !ext_hold;
    assign cnt_tc = (cnt == CW'(1));
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = ram_wren ? DONE : WAIT;
            WAIT:    if (cnt_tc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            winner   <= '0;
            grant    <= '0;
            cnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ram_addr <= win_addr;
                        ram_din  <= win_wdata;
                        ram_wren <= win_we;
                        winner   <= win_idx;
                        grant    <= win_mask;
                    end
                end
                ISSUE: begin
                    ram_wren <= 1'b0;
                    cnt      <= CW'(RD_LAT);
                    if (ram_wren) begin
                        ack <= grant;
                    end
                end
                WAIT: begin
                    if (cnt_tc) begin
                        for (int k = 0; k < NCORES; k++) begin
                            if (grant[k]) begin
                                rdata[k*DW +: DW] <= ram_q;
                            end
                        end
                        ack <= grant;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    ptr <= (winner == PW'(NCORES - 1)) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dram_rr_arbiter.md
# dram_rr_arbiter

Round-robin arbiter and sequencer that shares one single-port 8-bit data RAM among `NCORES` SIMD cores. It sits between the core load/store ports and the RAM. Each access runs a req/ack handshake, and the block drives RAM address, data and write-enable with a fixed read latency. Reads from several cores to the same address are coalesced into one RAM access and broadcast. An external hold input yields the RAM to another master.

## Interface
- `NCORES`, 4: number of requesting cores (2..8).
- `AW`, 8: RAM address width.
- `DW`, 8: RAM data width.
- `RD_LAT`, 2: cycles from `ram_addr` presented to `ram_q` valid (1..3).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NCORES  per-core access request; held until ack.
- `we`  in  NCORES  per-core 1=write, 0=read; stable while `req`.
- `addr`  in  NCORES*AW  core k address = `addr[k*AW +: AW]`.
- `wdata`  in  NCORES*DW  core k write data, same slicing.
- `ext_hold`  in  1  external master owns RAM; no new grant while high.
- `ram_q`  in  DW  RAM read data.
- `ack`  out  NCORES  one-cycle completion pulse per served core.
- `rdata`  out  NCORES*DW  per-core read result register, held until next read by that core.
- `ram_addr`  out  AW  registered RAM address.
- `ram_din`  out  DW  registered RAM write data.
- `ram_wren`  out  1  registered RAM write enable.
- `busy`  out  1  high when state != IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. `ptr` (log2 NCORES bits) = highest-priority core.
- IDLE:
  - If `ext_hold`=1 or `req`=0, stay.
  - Otherwise winner = first core with `req` set scanning ptr, ptr+1, … mod NCORES.
  - Latch winner address/data/we into `ram_addr`/`ram_din`/`ram_wren`. Go to ISSUE.
  - Grant mask = winner only for a write.
  - For a read, grant mask = winner plus every other requesting core with `we`=0 and an identical address (broadcast).
  - Writes are never coalesced.
- ISSUE: one cycle with RAM signals valid.
  - Write: `ram_wren`=1 this cycle only; next state is DONE.
  - Read: next state is WAIT with counter = RD_LAT.
- WAIT: decrement the counter each cycle. In the cycle where it reaches 1, copy `ram_q` into `rdata` of every core in the grant mask. Next state is DONE.
- DONE:
  - `ack`=grant mask for exactly this cycle; `ptr` <= winner+1 mod NCORES; `ram_wren`=0.
  - Next state is IDLE.
- Requests are sampled only in IDLE. A core must drop `req` by the cycle after its `ack`; if `req` is still high in IDLE it is treated as a new request.
- `ext_hold` is ignored once a transaction has left IDLE; that transaction completes normally.
- `ram_addr`/`ram_din` hold their last value in IDLE. `ram_wren` is 0 in all states except ISSUE of a write.
- Two writes to the same address are serialized in round-robin order; the later grant's data persists. A read served after a write to the same address returns the new data.
- Reset values: state IDLE, `ptr`=0, `ack`=0, `rdata`=0, `ram_addr`=0, `ram_din`=0, `ram_wren`=0, `busy`=0.
- Reset mid-transaction: everything returns to reset values on that edge and no `ack` is issued.
  - A write whose ISSUE cycle has already completed may have committed to RAM.
  - In-flight read data is discarded.

## Timing
- Request first seen in IDLE at cycle T: ISSUE at T+1.
- Write: `ack` at T+2; IDLE at T+3. One write costs 3 cycles.
- Read: `ram_q` sampled in cycle T+1+RD_LAT; `rdata` valid and `ack` at T+2+RD_LAT. One read costs RD_LAT+3 cycles; RD_LAT=2 gives `ack` at T+4.
- `rdata` changes only on the edge entering DONE, so it is valid in the same cycle as `ack`.
- `busy` is high from T+1 through the DONE cycle.
- Worst-case wait for any core: NCORES-1 full transactions plus its own.

## Test plan
- Single read, RD_LAT=2: core1 `req`, `we`=0, addr 0x10, RAM[0x10]=0xA5 → `ram_addr`=0x10 at T+1, `ack`=4'b0010 at T+4, `rdata[15:8]`=0xA5; other `rdata` unchanged.
- Write then read: core0 writes 0x3C to 0x22, then core2 reads 0x22 → `ram_wren`=1 only in cycle T+1, core0 `ack` at T+2, core2 `rdata`=0x3C.
- Round-robin: all 4 cores hold write requests to distinct addresses from reset → grants in order 0,1,2,3, `ack` every 3 cycles. Re-raising all after that yields order 0,1,2,3 again (ptr wrapped to 0).
- Broadcast: cores 0,2,3 read 0x40 and core1 writes 0x40, ptr=0 → one read with `ack`=4'b1101 and all three `rdata` equal to RAM[0x40]; the core1 write follows as a separate transaction.
- `ext_hold`: hold=1 while core3 requests → no RAM activity and `busy`=0; hold drops at cycle H → ISSUE at H+1. Hold raised during WAIT → transaction still acks.
- Reset mid-read: `rst` pulsed during WAIT → next cycle all outputs at reset values, no `ack`; a request held afterwards is served normally from ptr=0.
